// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction fetch stage. Owns the fetch PC, issues word addresses
//            to a synchronous instruction memory (data returns one cycle after
//            the request), buffers {pc, instruction} pairs in a small FIFO and
//            presents them downstream over a valid/ready handshake. A redirect
//            flushes buffered and in-flight instructions and restarts fetch.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_req, i_addr       - fetch request / word-aligned fetch address
//            instruction         - memory read data (cycle after i_req)
//            inst_out, pc_out    - head-of-FIFO instruction and its PC
//            inst_valid          - FIFO non-empty
//            inst_ready          - downstream accepts head this cycle
//            redirect            - flush and restart fetch at redirect_pc
//            redirect_pc         - new fetch PC (bits [1:0] forced to 0)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic [31:0] instruction,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] OCC_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   CREDITS  = (CW+1)'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   ipc_q, ipc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [CW:0]   w_used;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  // Credit check uses registered occupancy only: a pop this cycle does not
  // free a slot until the next cycle, which keeps i_req off the ready path.
  assign w_used  = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
  assign w_issue = !rst && !redirect && (w_used < CREDITS);

  // A response arriving during a redirect belongs to the old stream.
  assign w_push  = inflight_q && !redirect && !rst;
  assign w_pop   = inst_valid && inst_ready;

  assign i_req      = w_issue;
  assign i_addr     = fpc_q;
  assign inst_valid = (occ_q != '0);
  assign inst_out   = inst_valid ? inst_mem[rd_q] : 32'h0;
  assign pc_out     = inst_valid ? pc_mem[rd_q]   : 32'h0;

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = inflight_q;
    ipc_d      = ipc_q;
    occ_d      = occ_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect) begin
      fpc_d      = redirect_pc & ~32'h3;
      inflight_d = 1'b0;
      occ_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      inflight_d = w_issue;
      if (w_issue) begin
        ipc_d = fpc_q;
        fpc_d = fpc_q + 32'd4;
      end
      if (w_push) begin
        wr_d = wr_q + 1'b1;
      end
      if (w_pop) begin
        rd_d = rd_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      ipc_q      <= RESET_PC;
      occ_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
      occ_q      <= occ_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Storage needs no reset: contents are only visible while occ_q != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem[wr_q]   <= ipc_q;
      inst_mem[wr_q] <= instruction;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Self-checking bench for fetch_buffer. A queue-based model of the
//            fetch stream is compared against the DUT every cycle; directed
//            phases add literal expectations (reset, latency, backpressure,
//            redirect, PC wrap via a second instance, reset with redirect).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction, instruction2;

  logic        i_req, i_req2;
  logic [31:0] i_addr, i_addr2;
  logic [31:0] inst_out, inst_out2;
  logic [31:0] pc_out, pc_out2;
  logic        inst_valid, inst_valid2;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr),
    .instruction(instruction), .inst_out(inst_out), .pc_out(pc_out),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .i_req(i_req2), .i_addr(i_addr2),
    .instruction(instruction2), .inst_out(inst_out2), .pc_out(pc_out2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffered instructions, fetch PC, one outstanding request.
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic        m_infl;
  logic [31:0] m_ipc;
  logic [31:0] m_fpc;
  logic        m_req;

  // Memory responder state: request seen in the previous cycle.
  logic        p_v, p_v2;
  logic [31:0] p_a, p_a2;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_inst.delete();
    m_infl = 1'b0;
    m_ipc  = 32'h0;
    m_fpc  = 32'h0;
  endtask

  // Compare DUT against model mid-cycle, away from the rising edge.
  task automatic sample();
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
    @(negedge clk);
    e_valid = (q_pc.size() > 0);
    e_pc    = e_valid ? q_pc[0]   : 32'h0;
    e_inst  = e_valid ? q_inst[0] : 32'h0;
    m_req   = !rst && !redirect && ((q_pc.size() + int'(m_infl)) < DEPTH);
    chk("i_req",      {31'b0, i_req},      {31'b0, m_req});
    chk("i_addr",     i_addr,              m_fpc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    chk("pc_out",     pc_out,              e_pc);
    chk("inst_out",   inst_out,            e_inst);
    p_v  = i_req;
    p_a  = i_addr;
    p_v2 = i_req2;
    p_a2 = i_addr2;
  endtask

  // Advance the model by one cycle and return memory data after the edge.
  task automatic advance();
    if (rst) begin
      model_reset();
    end else if (redirect) begin
      q_pc.delete();
      q_inst.delete();
      m_infl = 1'b0;
      m_fpc  = redirect_pc & ~32'h3;
    end else begin
      if (q_pc.size() > 0 && inst_ready) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (m_infl) begin
        q_pc.push_back(m_ipc);
        q_inst.push_back(memf(m_ipc));
      end
      if (m_req) begin
        m_infl = 1'b1;
        m_ipc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
      if (q_pc.size() > DEPTH) begin
        n_bad++;
        $display("FAIL occ_bound: occupancy %0d exceeds %0d", q_pc.size(), DEPTH);
      end
    end
    @(posedge clk);
    #1;
    instruction  = p_v  ? memf(p_a)  : $urandom();
    instruction2 = p_v2 ? memf(p_a2) : $urandom();
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  initial begin
    int nreq;
    rst = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    instruction = 32'h0; instruction2 = 32'h0;
    p_v = 1'b0; p_v2 = 1'b0; p_a = 32'h0; p_a2 = 32'h0; m_req = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state and basic streaming; dut2 exercises the PC wrap.
    sample();
    chk("rst_i_addr2", i_addr2, 32'hFFFF_FFF8);
    chk("rst_pc_out2", pc_out2, 32'h0);
    advance();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      case (c)
        0: begin
          chk("c0_i_req",  {31'b0, i_req}, 32'd1);
          chk("c0_i_addr", i_addr, 32'h0);
          chk("c0_i_addr2", i_addr2, 32'hFFFF_FFF8);
        end
        1: chk("c1_valid", {31'b0, inst_valid}, 32'd0);
        2: begin
          chk("c2_pc",   pc_out, 32'h0);
          chk("c2_inst", inst_out, 32'hA5A5_0000);
          chk("c2_pc2",  pc_out2, 32'hFFFF_FFF8);
        end
        3: begin
          chk("c3_pc",  pc_out, 32'h4);
          chk("c3_pc2", pc_out2, 32'hFFFF_FFFC);
        end
        4: chk("c4_pc2", pc_out2, 32'h0000_0000);
        5: chk("c5_pc2", pc_out2, 32'h0000_0004);
        default: ;
      endcase
      advance();
    end

    // Backpressure from cycle 0.
    rst = 1'b1; cyc(); rst = 1'b0;
    inst_ready = 1'b0;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (i_req) nreq++;
      advance();
    end
    chk("bp_reqs", 32'(nreq), 32'd4);
    inst_ready = 1'b1;
    sample();
    chk("bp_r0_pc",  pc_out, 32'h0);
    chk("bp_r0_req", {31'b0, i_req}, 32'd0);
    advance();
    sample();
    chk("bp_r1_req",  {31'b0, i_req}, 32'd1);
    chk("bp_r1_addr", i_addr, 32'h10);
    chk("bp_r1_pc",   pc_out, 32'h4);
    advance();
    sample(); chk("bp_r2_pc", pc_out, 32'h8); advance();
    sample(); chk("bp_r3_pc", pc_out, 32'hC); advance();
    sample(); chk("bp_r4_pc", pc_out, 32'h10); advance();

    // Redirect with 3 buffered and one in flight.
    rst = 1'b1; cyc(); rst = 1'b0;
    inst_ready = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    sample();
    chk("rd_req0",   {31'b0, i_req}, 32'd0);
    chk("rd_valid0", {31'b0, inst_valid}, 32'd1);
    advance();
    redirect = 1'b0; inst_ready = 1'b1;
    sample();
    chk("rd1_valid", {31'b0, inst_valid}, 32'd0);
    chk("rd1_req",   {31'b0, i_req}, 32'd1);
    chk("rd1_addr",  i_addr, 32'h0000_1000);
    advance();
    sample(); chk("rd2_valid", {31'b0, inst_valid}, 32'd0); advance();
    sample();
    chk("rd3_valid", {31'b0, inst_valid}, 32'd1);
    chk("rd3_pc",    pc_out, 32'h0000_1000);
    chk("rd3_inst",  inst_out, 32'hA5A5_1000);
    advance();

    // Random backpressure and redirects.
    for (int c = 0; c < 1000; c++) begin
      inst_ready  = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom();
      cyc();
    end
    redirect = 1'b0;

    // Fill the FIFO, then reset together with a redirect.
    inst_ready = 1'b0;
    for (int c = 0; c < 8; c++) cyc();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_2000;
    sample();
    chk("rr_req", {31'b0, i_req}, 32'd0);
    advance();
    rst = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    sample();
    chk("rr_valid", {31'b0, inst_valid}, 32'd0);
    chk("rr_pc",    pc_out, 32'h0);
    chk("rr_inst",  inst_out, 32'h0);
    chk("rr_addr",  i_addr, 32'h0);
    chk("rr_req1",  {31'b0, i_req}, 32'd1);
    advance();
    for (int c = 0; c < 6; c++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage sitting directly upstream of the decode/register-file/ALU datapath. Owns the fetch PC, issues word addresses to the synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. Presents one instruction per cycle to the downstream stage over a valid/ready handshake. A redirect input flushes buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  out  1  fetch request this cycle
- i_addr  out  32  fetch address (word aligned)
- instruction  in  32  memory read data, valid exactly one cycle after the i_req cycle
- inst_out  out  32  head-of-FIFO instruction; 0 when inst_valid=0
- pc_out  out  32  PC of inst_out; 0 when inst_valid=0
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  downstream accepts head this cycle
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced to 00)

## Operation
- State: fpc (next fetch PC), inflight flag + inflight_pc (one outstanding request), FIFO of {pc, instruction} with occupancy count occ (0..DEPTH).
- Issue rule: i_req=1 iff !rst && !redirect && (occ + inflight) < DEPTH, using registered values only (pop in same cycle not credited). On issue: i_addr=fpc, inflight_pc<=fpc, fpc<=fpc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
- i_addr always equals fpc, also when i_req=0.
- Response: in cycle after issue, instruction is pushed with inflight_pc unless squashed.
- Pop: inst_valid && inst_ready removes head. Push and pop in same cycle: occ unchanged, both take effect.
- Credit rule guarantees no push when full; no overflow handling required, assert in verification.
- Redirect (priority below rst, above everything else): FIFO emptied (occ<=0), in-flight response discarded, fpc<=redirect_pc & ~3, i_req=0 that cycle. A handshake completing in the redirect cycle counts as consumed by downstream; FIFO is still flushed.
- Redirect asserted on consecutive cycles: last one wins; no requests issued while held.

## Timing
- Reset values (cycle after rst high): fpc=RESET_PC, occ=0, inflight=0, i_req=0, i_addr=RESET_PC, inst_valid=0, inst_out=0, pc_out=0.
- Cycle 0 = first cycle rst low: i_req=1, i_addr=RESET_PC. Cycle 1: instruction sampled and pushed. Cycle 2: inst_valid=1, pc_out=RESET_PC.
- Fetch-to-output latency 2 cycles; redirect-to-output latency 3 cycles (redirect cycle, request, response, visible).
- Throughput 1 instruction/cycle with inst_ready held high (steady occ=1, inflight=1).
- inst_ready low: fetch stops once occ+inflight=DEPTH; occ reaches exactly DEPTH. After inst_ready returns high, first pop frees credit; request issues the following cycle.
- inst_out/pc_out are registered FIFO storage muxed with inst_valid; no combinational path from inst_ready or redirect to inst_valid/inst_out. i_req depends combinationally on redirect only.
- Empty FIFO: push becomes visible next cycle (no bypass).

## Test plan
- Reset release, inst_ready=1, memory returns mem[a]=a^32'hA5A5_0000: cycle 0 i_addr=0; cycle 2 onward inst_valid=1, pc_out=0,4,8,… one per cycle, inst_out matches.
- inst_ready=0 from cycle 0 for 10 cycles: exactly 4 requests issued (addr 0..C), occ=4, i_req=0; release ready → pcs 0,4,8,C popped in order, next request addr 10 one cycle after first pop, no gaps/duplicates.
- Redirect to 32'h0000_1003 with 3 entries buffered and one in flight: next cycle inst_valid=0; fetch resumes at 0x1000; first pc_out=0x1000 three cycles after redirect; squashed response never appears.
- RESET_PC=32'hFFFF_FFF8: pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Random inst_ready toggling, 1000 cycles, with random redirects: pc_out strictly follows fetch order within each redirect epoch, occ never exceeds DEPTH, inst_out=0 whenever inst_valid=0.
- rst asserted mid-stream with full FIFO and redirect=1 same cycle: next cycle all outputs at reset values, fetch restarts at RESET_PC.
